// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake plus instruction-memory write bus.
// master = byte source / memory side, slave = loader.
interface imem_loader_if #(
  parameter int ADDR_W = 12
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot loader, byte stream -> LE 32-bit words -> imem writes.
// Ports: clk, rst (async high), start, bus (slave: byte_in/valid/ready,
// mem_we/addr/wdata), core_hold, busy, done, error, words_loaded.
// Optional LOADER_CHECKSUM_EN: trailing 8-bit checksum byte + CHECK state.
module imem_loader #(
  parameter int ADDR_W    = 12,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  imem_loader_if.slave      bus,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-2:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [ADDR_W-2:0] ONE_W = 1;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [23:0]       asm_q, asm_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-2:0] words_q, words_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  logic        xfer;
  logic        last_word;
  logic [15:0] len_new;
  logic        ready;
`ifndef LOADER_CHECKSUM_EN
  // All words received: stop taking bytes while the final strobe drains,
  // so done lands the cycle after that strobe.
  logic        data_full;
  assign data_full = (16'(words_q) == len_q);
`endif

  always_comb begin
    ready = 1'b0;
    unique case (state_q)
      S_LEN_LO,
      S_LEN_HI:  ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_DATA:    ready = 1'b1;
      S_CHECK:   ready = 1'b1;
`else
      S_DATA:    ready = !data_full;
`endif
      default:   ready = 1'b0;
    endcase
  end

  assign xfer      = bus.byte_valid && ready;
  assign len_new   = {bus.byte_in, len_q[7:0]};
  assign last_word = (16'(words_q + ONE_W) == len_q);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    asm_d   = asm_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    words_d = words_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    unique case (state_q)
      S_IDLE,
      S_DONE,
      S_ERROR: begin
        if (start) begin
          state_d = S_LEN_LO;
          words_d = '0;
          cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = bus.byte_in;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d = len_new;
          if (len_new == 16'd0 || len_new > 16'(MAX_WORDS))
            state_d = S_ERROR;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
`ifndef LOADER_CHECKSUM_EN
        if (data_full)
          state_d = S_DONE;
`endif
        if (xfer) begin
          cnt_d = cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          sum_d = sum_q + bus.byte_in;
`endif
          unique case (cnt_q)
            2'd0: asm_d[7:0]   = bus.byte_in;
            2'd1: asm_d[15:8]  = bus.byte_in;
            2'd2: asm_d[23:16] = bus.byte_in;
            default: begin
              wdata_d = {bus.byte_in, asm_q};
              addr_d  = {words_q[ADDR_W-3:0], 2'b00};
              we_d    = 1'b1;
              words_d = words_q + ONE_W;
`ifdef LOADER_CHECKSUM_EN
              if (last_word)
                state_d = S_CHECK;
`endif
            end
          endcase
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (xfer) begin
          if (8'(sum_q + bus.byte_in) == 8'd0)
            state_d = S_DONE;
          else
            state_d = S_ERROR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      asm_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      words_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      asm_q   <= asm_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      words_q <= words_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign bus.byte_ready = ready;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;

  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE)
                     && (state_q != S_ERROR);
  assign done         = (state_q == S_DONE);
  assign error        = (state_q == S_ERROR);
  assign core_hold    = (state_q != S_DONE);
  assign words_loaded = words_q;

  // last_word only steers the CHECK entry; keep it referenced otherwise.
`ifndef LOADER_CHECKSUM_EN
  logic unused_ok;
  assign unused_ok = last_word;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
// Default build (no checksum).
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        core_hold, busy, done, error;
  logic [10:0] words_loaded;

  imem_loader_if #(.ADDR_W(12)) bus();

  imem_loader #(.ADDR_W(12), .MAX_WORDS(1024)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (bus.slave),
    .core_hold    (core_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int stalls = 0;
  logic [11:0] wa[$];
  logic [31:0] wd[$];

  always @(posedge clk)
    if (bus.mem_we) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_wdata);
    end

  task automatic put_byte(input logic [7:0] b);
    int n = 0;
    bus.byte_in = b;
    bus.byte_valid = 1'b1;
    while (!bus.byte_ready && n < 50) begin
      @(negedge clk);
      n++;
      stalls++;
    end
    if (!bus.byte_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL put_byte timeout: byte_ready=0 want 1");
    end
    @(negedge clk);
  endtask

  task automatic put_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) put_byte(w[8*i +: 8]);
  endtask

  task automatic idle(input int n);
    bus.byte_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [31:0] big_word(input int i);
    return (32'(i) * 32'h01000193) ^ 32'h5A5A0000;
  endfunction

  task automatic test_reset();
    n_cmp++;
    if ({bus.byte_ready, bus.mem_we, core_hold, busy, done, error}
        !== 6'b001000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 001000",
        {bus.byte_ready, bus.mem_we, core_hold, busy, done, error});
    end
    n_cmp++;
    if ({bus.mem_addr, bus.mem_wdata, words_loaded} !== 55'd0) begin
      n_bad++;
      $display("FAIL reset_regs: addr=%h wdata=%h words=%0d want 0",
        bus.mem_addr, bus.mem_wdata, words_loaded);
    end
  endtask

  task automatic test_two_word();
    wa.delete(); wd.delete(); stalls = 0;
    do_start();
    n_cmp++;
    if ({busy, bus.byte_ready, core_hold, done} !== 4'b1110) begin
      n_bad++;
      $display("FAIL start_state: got %b want 1110",
        {busy, bus.byte_ready, core_hold, done});
    end
    put_byte(8'h02); put_byte(8'h00);
    put_word(32'h00000013);
    n_cmp++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, words_loaded}
        !== {1'b1, 12'h000, 32'h00000013, 11'd1}) begin
      n_bad++;
      $display("FAIL write_latency: we=%b addr=%h data=%h words=%0d want 1 000 00000013 1",
        bus.mem_we, bus.mem_addr, bus.mem_wdata, words_loaded);
    end
    put_word(32'h00100093);
    n_cmp++;
    if ({bus.mem_we, done, core_hold} !== 3'b101) begin
      n_bad++;
      $display("FAIL last_strobe: we/done/hold=%b want 101",
        {bus.mem_we, done, core_hold});
    end
    idle(1);
    n_cmp++;
    if ({done, core_hold, busy, bus.byte_ready, error, words_loaded}
        !== {5'b10000, 11'd2}) begin
      n_bad++;
      $display("FAIL two_word_done: flags=%b words=%0d want 10000 2",
        {done, core_hold, busy, bus.byte_ready, error}, words_loaded);
    end
    n_cmp++;
    if (wa.size() != 2 || wa[0] !== 12'h000 || wd[0] !== 32'h00000013
        || wa[1] !== 12'h004 || wd[1] !== 32'h00100093) begin
      n_bad++;
      $display("FAIL two_word_writes: n=%0d want 2 (00000013@000, 00100093@004)",
        wa.size());
    end
    n_cmp++;
    if (stalls != 0) begin
      n_bad++;
      $display("FAIL full_rate: stalls=%0d want 0", stalls);
    end
  endtask

  task automatic test_len_zero();
    wa.delete(); wd.delete();
    do_start();
    put_byte(8'h00); put_byte(8'h00);
    idle(0);
    n_cmp++;
    if ({error, done, core_hold, bus.byte_ready, busy} !== 5'b10100
        || wa.size() != 0) begin
      n_bad++;
      $display("FAIL len_zero: flags=%b writes=%0d want 10100 0",
        {error, done, core_hold, bus.byte_ready, busy}, wa.size());
    end
    do_start();
    n_cmp++;
    if ({error, busy, words_loaded} !== {2'b01, 11'd0}) begin
      n_bad++;
      $display("FAIL recover_start: err/busy=%b words=%0d want 01 0",
        {error, busy}, words_loaded);
    end
    put_byte(8'h01); put_byte(8'h00);
    put_word(32'hA1B2C3D4);
    idle(1);
    n_cmp++;
    if (!done || wa.size() != 1 || wa[0] !== 12'h000
        || wd[0] !== 32'hA1B2C3D4) begin
      n_bad++;
      $display("FAIL recover_load: done=%b writes=%0d want 1 1 (A1B2C3D4@000)",
        done, wa.size());
    end
  endtask

  task automatic test_len_max();
    wa.delete(); wd.delete();
    do_start();
    put_byte(8'h01); put_byte(8'h04);
    idle(0);
    n_cmp++;
    if ({error, core_hold} !== 2'b11 || wa.size() != 0) begin
      n_bad++;
      $display("FAIL len_1025: err/hold=%b writes=%0d want 11 0",
        {error, core_hold}, wa.size());
    end
    wa.delete(); wd.delete(); stalls = 0;
    do_start();
    put_byte(8'h00); put_byte(8'h04);
    for (int i = 0; i < 1024; i++) put_word(big_word(i));
    idle(1);
    n_cmp++;
    if (!done || core_hold || words_loaded !== 11'd1024
        || wa.size() != 1024) begin
      n_bad++;
      $display("FAIL len_1024: done=%b hold=%b words=%0d writes=%0d want 1 0 1024 1024",
        done, core_hold, words_loaded, wa.size());
    end
    n_cmp++;
    if (wa.size() == 1024) begin
      int bad = 0;
      for (int i = 0; i < 1024; i++)
        if (wa[i] !== 12'(i * 4) || wd[i] !== big_word(i)) bad++;
      if (bad != 0 || wa[1023] !== 12'hFFC) begin
        n_bad++;
        $display("FAIL len_1024_data: bad=%0d last=%h want 0 ffc",
          bad, wa[1023]);
      end
    end else begin
      n_bad++;
      $display("FAIL len_1024_data: writes=%0d want 1024", wa.size());
    end
    n_cmp++;
    if (stalls != 0) begin
      n_bad++;
      $display("FAIL len_1024_rate: stalls=%0d want 0", stalls);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] bytes [14];
    int gaps [14];
    bytes = '{8'h03, 8'h00,
              8'hEF, 8'hBE, 8'hAD, 8'hDE,
              8'h78, 8'h56, 8'h34, 8'h12,
              8'h0D, 8'hF0, 8'hFE, 8'hCA};
    gaps  = '{1, 0, 3, 0, 2, 1, 0, 4, 1, 0, 2, 0, 3, 1};
    wa.delete(); wd.delete();
    do_start();
    for (int i = 0; i < 14; i++) begin
      idle(gaps[i]);
      put_byte(bytes[i]);
    end
    idle(1);
    n_cmp++;
    if (!done || words_loaded !== 11'd3 || wa.size() != 3) begin
      n_bad++;
      $display("FAIL gaps_done: done=%b words=%0d writes=%0d want 1 3 3",
        done, words_loaded, wa.size());
    end
    n_cmp++;
    if (wa.size() != 3 || wd[0] !== 32'hDEADBEEF || wd[1] !== 32'h12345678
        || wd[2] !== 32'hCAFEF00D || wa[0] !== 12'h000
        || wa[1] !== 12'h004 || wa[2] !== 12'h008) begin
      n_bad++;
      $display("FAIL gaps_writes: n=%0d want DEADBEEF@000 12345678@004 CAFEF00D@008",
        wa.size());
    end
  endtask

  task automatic test_start_ignored();
    wa.delete(); wd.delete();
    do_start();
    put_byte(8'h02); put_byte(8'h00);
    put_word(32'h11223344);
    put_byte(8'h88);
    bus.byte_valid = 1'b0;
    do_start();
    n_cmp++;
    if ({busy, done, words_loaded} !== {2'b10, 11'd1}) begin
      n_bad++;
      $display("FAIL start_in_data: busy/done=%b words=%0d want 10 1",
        {busy, done}, words_loaded);
    end
    put_byte(8'h77); put_byte(8'h66); put_byte(8'h55);
    idle(1);
    n_cmp++;
    if (!done || wa.size() != 2 || wd[0] !== 32'h11223344
        || wd[1] !== 32'h55667788 || wa[1] !== 12'h004) begin
      n_bad++;
      $display("FAIL start_ignored_load: done=%b writes=%0d want 1 2",
        done, wa.size());
    end
  endtask

  task automatic test_reset_mid();
    wa.delete(); wd.delete();
    do_start();
    put_byte(8'h02); put_byte(8'h00);
    put_word(32'hCAFEBABE);
    put_byte(8'h01);
    bus.byte_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    test_reset();
    n_cmp++;
    if (wa.size() != 1 || wd[0] !== 32'hCAFEBABE) begin
      n_bad++;
      $display("FAIL reset_mid_writes: writes=%0d want 1 (CAFEBABE)",
        wa.size());
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, core_hold, bus.byte_ready} !== 3'b010) begin
      n_bad++;
      $display("FAIL post_reset_idle: busy/hold/ready=%b want 010",
        {busy, core_hold, bus.byte_ready});
    end
  endtask

  initial begin
    bus.byte_in = 8'h00;
    bus.byte_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_two_word();
    test_len_zero();
    test_len_max();
    test_gaps();
    test_start_ignored();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
